peak_window_sched: RTL

//  Controller for the per-channel absolute-peak detectors. Generates the periodic

---
 rtl/peak_window_sched_pkg.sv | 15 +
 rtl/peak_window_sched_if.sv | 15 +
 rtl/peak_window_sched_timer.sv | 62 ++++++
 rtl/peak_window_sched.sv | 112 +++++++++++
 4 files changed

// File: rtl/peak_window_sched_pkg.sv
// Shared constants and types for the peak-window scheduler: channel geometry,
// window timing defaults and the readout state encoding.
package peak_window_sched_pkg;
  localparam int NCH        = 4;
  localparam int DW         = 48;
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PULSE_LEN  = 4;
  localparam int SETTLE_CYC = 4;
  localparam int MIN_PERIOD = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;
endpackage

// File: rtl/peak_window_sched_if.sv
// Readout stream: one snapshotted channel maximum per beat, valid/ready handshake.
interface peak_window_sched_if;
  import peak_window_sched_pkg::*;

  logic [DW-1:0]  out_data;
  logic [CHW-1:0] out_ch;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (output out_data, output out_ch, output out_valid, output out_last,
                  input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, input out_last,
                  output out_ready);
endinterface

// File: rtl/peak_window_sched_timer.sv
// Window timebase: period counter with latched/clamped length, the shared ms strobe,
// and the settle timer that raises a one-cycle capture pulse after each strobe rise.
module peak_win_timer
  import peak_window_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] period_len,
  output logic        ms_out,
  output logic        cap
);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  logic [31:0]   pcnt_q, pcnt_d;
  logic [31:0]   per_q, per_d, per_eff;
  logic          ms_q, ms_d;
  logic          cap_q, cap_d;
  logic [SW-1:0] scnt_q, scnt_d;

  // pcnt is the phase of the strobe presented in the following cycle.
  always_comb begin
    pcnt_d  = '0;
    per_d   = per_q;
    per_eff = per_q;
    ms_d    = 1'b0;
    scnt_d  = '0;
    cap_d   = 1'b0;
    if (enable) begin
      if (pcnt_q == '0) begin
        per_eff = (period_len < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period_len;
        per_d   = per_eff;
      end
      pcnt_d = (pcnt_q >= per_eff - 32'd1) ? '0 : pcnt_q + 32'd1;
      ms_d   = (pcnt_q < 32'(PULSE_LEN));
      if (ms_d && !ms_q)
        scnt_d = SW'(SETTLE_CYC);
      else if (scnt_q != '0)
        scnt_d = scnt_q - SW'(1);
      cap_d = (scnt_q == SW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      per_q  <= '0;
      ms_q   <= 1'b0;
      scnt_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      ms_q   <= ms_d;
      scnt_q <= scnt_d;
      cap_q  <= cap_d;
    end
  end

  assign ms_out = ms_q;
  assign cap    = cap_q;
endmodule

// File: rtl/peak_window_sched.sv
// Peak-detector window controller: drives the shared window strobe, snapshots all
// channel maxima on capture and streams them out one channel per beat.
module peak_window_sched
  import peak_window_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [31:0]         period_len,
  input  logic                clr_overrun,
  input  logic [NCH*DW-1:0]   max_in,
  output logic                ms_out,
  output logic [15:0]         win_cnt,
  output logic                overrun,
  peak_window_sched_if.master out_if
);
  logic cap;

  peak_win_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period_len (period_len),
    .ms_out     (ms_out),
    .cap        (cap)
  );

  rd_state_e      state_q, state_d;
  logic [DW-1:0]  buf_q [NCH];
  logic [DW-1:0]  buf_d [NCH];
  logic [CHW-1:0] ch_q, ch_d, nxt;
  logic [DW-1:0]  data_q, data_d;
  logic           valid_q, valid_d, last_q, last_d;
  logic [15:0]    win_q, win_d;
  logic           ovr_q, ovr_d;
  logic           hs, load;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    win_d   = win_q;
    ovr_d   = ovr_q & ~clr_overrun;
    hs      = valid_q & out_if.out_ready;
    nxt     = ch_q + CHW'(1);
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = cap;
      SEND: begin
        if (hs && last_q) begin
          // A capture landing on the final handshake starts the next packet back-to-back.
          if (cap) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end else begin
          if (cap) ovr_d = 1'b1;
          if (hs) begin
            ch_d   = nxt;
            data_d = buf_q[nxt];
            last_d = (nxt == CHW'(NCH - 1));
          end
        end
      end
      default: ;
    endcase
    if (load) begin
      for (int k = 0; k < NCH; k++) buf_d[k] = max_in[k*DW +: DW];
      win_d   = win_q + 16'd1;
      state_d = SEND;
      ch_d    = '0;
      data_d  = max_in[DW-1:0];
      valid_d = 1'b1;
      last_d  = (NCH == 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < NCH; k++) buf_q[k] <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      win_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      win_q   <= win_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = ch_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign win_cnt          = win_q;
  assign overrun          = ovr_q;
endmodule
